// File: rtl/md4_round1_seq_if.sv
// Handshake and data bundle for the sequential MD4 round-1 engine.
// slave = the engine, master = the block loader driving it.
interface md4_round1_seq_if;
    logic         start_i;
    logic [31:0]  a_i;
    logic [31:0]  b_i;
    logic [31:0]  c_i;
    logic [31:0]  d_i;
    logic [511:0] x_i;
    logic         ready_o;
    logic         busy_o;
    logic         done_o;
    logic [31:0]  out_a_o;
    logic [31:0]  out_b_o;
    logic [31:0]  out_c_o;
    logic [31:0]  out_d_o;

    modport slave (
        input  start_i, a_i, b_i, c_i, d_i, x_i,
        output ready_o, busy_o, done_o, out_a_o, out_b_o, out_c_o, out_d_o
    );

    modport master (
        output start_i, a_i, b_i, c_i, d_i, x_i,
        input  ready_o, busy_o, done_o, out_a_o, out_b_o, out_c_o, out_d_o
    );
endinterface

// File: rtl/md4_round1_seq.sv
// Iterative MD4 round-1 engine: one step per clock over a shared F/add/rotate datapath.
// Define MD4_R1_FEEDFORWARD_EN to add the initial chaining words into the results.
module md4_round1_seq (
    input  logic            clk,
    input  logic            rst,
    md4_round1_seq_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_e;

    state_e       state_q, state_d;
    logic [3:0]   step_q, step_d;
    logic [31:0]  regA_q, regB_q, regC_q, regD_q;
    logic [31:0]  regA_d, regB_d, regC_d, regD_d;
    logic [511:0] words_q, words_d;
    logic [31:0]  outA_q, outB_q, outC_q, outD_q;
    logic [31:0]  outA_d, outB_d, outC_d, outD_d;
    logic         done_q, done_d;
    logic [31:0]  target, opP, opQ, opR, funcF, msgWord, sum, rotated;
    logic [31:0]  addA, addB, addC, addD;

`ifdef MD4_R1_FEEDFORWARD_EN
    logic [31:0]  initA_q, initB_q, initC_q, initD_q;
    logic [31:0]  initA_d, initB_d, initC_d, initD_d;

    assign addA = initA_q;
    assign addB = initB_q;
    assign addC = initC_q;
    assign addD = initD_q;
`else
    assign addA = 32'd0;
    assign addB = 32'd0;
    assign addC = 32'd0;
    assign addD = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= 4'd0;
            regA_q  <= 32'd0;
            regB_q  <= 32'd0;
            regC_q  <= 32'd0;
            regD_q  <= 32'd0;
            words_q <= 512'd0;
            outA_q  <= 32'd0;
            outB_q  <= 32'd0;
            outC_q  <= 32'd0;
            outD_q  <= 32'd0;
            done_q  <= 1'b0;
`ifdef MD4_R1_FEEDFORWARD_EN
            initA_q <= 32'd0;
            initB_q <= 32'd0;
            initC_q <= 32'd0;
            initD_q <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            regA_q  <= regA_d;
            regB_q  <= regB_d;
            regC_q  <= regC_d;
            regD_q  <= regD_d;
            words_q <= words_d;
            outA_q  <= outA_d;
            outB_q  <= outB_d;
            outC_q  <= outC_d;
            outD_q  <= outD_d;
            done_q  <= done_d;
`ifdef MD4_R1_FEEDFORWARD_EN
            initA_q <= initA_d;
            initB_q <= initB_d;
            initC_q <= initC_d;
            initD_q <= initD_d;
`endif
        end
    end

    // Operand rotation: the register being overwritten is the accumulator, the other three feed F.
    always_comb begin
        target = regA_q;
        opP    = regB_q;
        opQ    = regC_q;
        opR    = regD_q;
        case (step_q[1:0])
            2'd1: begin target = regD_q; opP = regA_q; opQ = regB_q; opR = regC_q; end
            2'd2: begin target = regC_q; opP = regD_q; opQ = regA_q; opR = regB_q; end
            2'd3: begin target = regB_q; opP = regC_q; opQ = regD_q; opR = regA_q; end
            default: ;
        endcase
        funcF   = (opP & opQ) | (~opP & opR);
        msgWord = words_q[{step_q, 5'd0} +: 32];
        sum     = target + funcF + msgWord;
        case (step_q[1:0])
            2'd0:    rotated = {sum[28:0], sum[31:29]};
            2'd1:    rotated = {sum[24:0], sum[31:25]};
            2'd2:    rotated = {sum[20:0], sum[31:21]};
            default: rotated = {sum[12:0], sum[31:13]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        regA_d  = regA_q;
        regB_d  = regB_q;
        regC_d  = regC_q;
        regD_d  = regD_q;
        words_d = words_q;
        outA_d  = outA_q;
        outB_d  = outB_q;
        outC_d  = outC_q;
        outD_d  = outD_q;
        done_d  = 1'b0;
`ifdef MD4_R1_FEEDFORWARD_EN
        initA_d = initA_q;
        initB_d = initB_q;
        initC_d = initC_q;
        initD_d = initD_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = RUN;
                    step_d  = 4'd0;
                    regA_d  = bus.a_i;
                    regB_d  = bus.b_i;
                    regC_d  = bus.c_i;
                    regD_d  = bus.d_i;
                    words_d = bus.x_i;
`ifdef MD4_R1_FEEDFORWARD_EN
                    initA_d = bus.a_i;
                    initB_d = bus.b_i;
                    initC_d = bus.c_i;
                    initD_d = bus.d_i;
`endif
                end
            end
            default: begin
                case (step_q[1:0])
                    2'd0:    regA_d = rotated;
                    2'd1:    regD_d = rotated;
                    2'd2:    regC_d = rotated;
                    default: regB_d = rotated;
                endcase
                // Step 15 always writes B, so its fresh value comes straight from the datapath.
                if (step_q == 4'd15) begin
                    state_d = IDLE;
                    step_d  = 4'd0;
                    done_d  = 1'b1;
                    outA_d  = regA_q + addA;
                    outB_d  = rotated + addB;
                    outC_d  = regC_q + addC;
                    outD_d  = regD_q + addD;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
        endcase
    end

    always_comb begin
        bus.ready_o = (state_q == IDLE);
        bus.busy_o  = (state_q == RUN);
        bus.done_o  = done_q;
        bus.out_a_o = outA_q;
        bus.out_b_o = outB_q;
        bus.out_c_o = outC_q;
        bus.out_d_o = outD_q;
    end
endmodule

// File: tb/tb_md4_round1_seq.sv
// Directed bench for md4_round1_seq: reset, latency, hold-off, abort and back-to-back blocks.
// Expected results follow MD4_R1_FEEDFORWARD_EN when it is defined.
module tb_md4_round1_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    md4_round1_seq_if bus ();

    md4_round1_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Caller sits just after an edge; this drives a request and returns just after the capture edge.
    task automatic applyStimulus(input logic [31:0] va, vb, vc, vd, input logic [511:0] vx, input logic holdStart);
        bus.a_i     = va;
        bus.b_i     = vb;
        bus.c_i     = vc;
        bus.d_i     = vd;
        bus.x_i     = vx;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        if (!holdStart) bus.start_i = 1'b0;
    endtask

    task automatic waitDone(output int cycles, output int busyCount);
        cycles    = 0;
        busyCount = int'(bus.busy_o);
        while (!bus.done_o && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            if (!bus.done_o) busyCount += int'(bus.busy_o);
        end
    endtask

    function automatic logic [127:0] modelRound1(input logic [31:0] ia, ib, ic, id, input logic [511:0] blk);
        logic [31:0] v [4];
        int          shifts [4];
        int          tgt;
        logic [31:0] f;
        logic [31:0] s;
        v[0] = ia; v[1] = ib; v[2] = ic; v[3] = id;
        shifts[0] = 3; shifts[1] = 7; shifts[2] = 11; shifts[3] = 19;
        for (int k = 0; k < 16; k++) begin
            tgt    = (4 - (k % 4)) % 4;
            f      = (v[(tgt + 1) % 4] & v[(tgt + 2) % 4]) | (~v[(tgt + 1) % 4] & v[(tgt + 3) % 4]);
            s      = v[tgt] + f + blk[32 * k +: 32];
            v[tgt] = (s << shifts[k % 4]) | (s >> (32 - shifts[k % 4]));
        end
`ifdef MD4_R1_FEEDFORWARD_EN
        v[0] = v[0] + ia; v[1] = v[1] + ib; v[2] = v[2] + ic; v[3] = v[3] + id;
`endif
        return {v[0], v[1], v[2], v[3]};
    endfunction

    initial begin
        int           cycles;
        int           busyCount;
        int           doneSeen;
        logic [31:0]  expOneA;
        logic [31:0]  ra, rb, rc, rd;
        logic [511:0] rx;
        logic [127:0] expected;

        checks   = 0;
        errors   = 0;
`ifdef MD4_R1_FEEDFORWARD_EN
        expOneA  = 32'h00089801;
`else
        expOneA  = 32'h00089800;
`endif
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.c_i     = '0;
        bus.d_i     = '0;
        bus.x_i     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_ready", 32'(bus.ready_o), 32'd1);
        checkOutput("reset_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("reset_done", 32'(bus.done_o), 32'd0);
        checkOutput("reset_out_a", bus.out_a_o, 32'h0);
        checkOutput("reset_out_b", bus.out_b_o, 32'h0);
        checkOutput("reset_out_c", bus.out_c_o, 32'h0);
        checkOutput("reset_out_d", bus.out_d_o, 32'h0);

        $display("[TB] all-zero block");
        applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 512'h0, 1'b0);
        checkOutput("zero_busy_after_start", 32'(bus.busy_o), 32'd1);
        checkOutput("zero_ready_after_start", 32'(bus.ready_o), 32'd0);
        waitDone(cycles, busyCount);
        checkOutput("zero_latency", 32'(cycles), 32'd16);
        checkOutput("zero_busy_cycles", 32'(busyCount), 32'd16);
        checkOutput("zero_ready_at_done", 32'(bus.ready_o), 32'd1);
        checkOutput("zero_out_a", bus.out_a_o, 32'h0);
        checkOutput("zero_out_d", bus.out_d_o, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("zero_done_pulse", 32'(bus.done_o), 32'd0);

        $display("[TB] a=1 block");
        applyStimulus(32'h1, 32'h0, 32'h0, 32'h0, 512'h0, 1'b0);
        waitDone(cycles, busyCount);
        checkOutput("one_latency", 32'(cycles), 32'd16);
        checkOutput("one_out_a", bus.out_a_o, expOneA);
        checkOutput("one_out_b", bus.out_b_o, 32'h40010045);
        checkOutput("one_out_c", bus.out_c_o, 32'hC5408100);
        checkOutput("one_out_d", bus.out_d_o, 32'h08888800);

        $display("[TB] start held, inputs disturbed during run");
        applyStimulus(32'h1, 32'h0, 32'h0, 32'h0, 512'h0, 1'b1);
        bus.a_i = 32'hFFFFFFFF;
        bus.c_i = 32'h12345678;
        bus.x_i = {16{32'hDEADBEEF}};
        waitDone(cycles, busyCount);
        checkOutput("held_latency", 32'(cycles), 32'd16);
        checkOutput("held_out_a", bus.out_a_o, expOneA);
        checkOutput("held_out_b", bus.out_b_o, 32'h40010045);
        checkOutput("held_out_c", bus.out_c_o, 32'hC5408100);
        checkOutput("held_out_d", bus.out_d_o, 32'h08888800);
        applyStimulus(32'h1, 32'h0, 32'h0, 32'h0, 512'h0, 1'b0);
        checkOutput("restart_done_low", 32'(bus.done_o), 32'd0);
        checkOutput("restart_busy", 32'(bus.busy_o), 32'd1);
        waitDone(cycles, busyCount);
        checkOutput("restart_done_spacing", 32'(cycles + 1), 32'd17);
        checkOutput("restart_out_b", bus.out_b_o, 32'h40010045);

        $display("[TB] reset during run");
        applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 512'h0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort_ready", 32'(bus.ready_o), 32'd1);
        checkOutput("abort_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("abort_done", 32'(bus.done_o), 32'd0);
        checkOutput("abort_out_a", bus.out_a_o, 32'h0);
        checkOutput("abort_out_b", bus.out_b_o, 32'h0);
        doneSeen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            doneSeen += int'(bus.done_o);
        end
        checkOutput("abort_no_done", 32'(doneSeen), 32'd0);
        applyStimulus(32'h0, 32'h0, 32'h0, 32'h0, 512'h0, 1'b0);
        waitDone(cycles, busyCount);
        checkOutput("fresh_latency", 32'(cycles), 32'd16);
        checkOutput("fresh_out_c", bus.out_c_o, 32'h0);

        $display("[TB] back-to-back random blocks");
        for (int blk = 0; blk < 24; blk++) begin
            ra = $urandom;
            rb = $urandom;
            rc = $urandom;
            rd = $urandom;
            for (int w = 0; w < 16; w++) rx[32 * w +: 32] = $urandom;
            expected = modelRound1(ra, rb, rc, rd, rx);
            applyStimulus(ra, rb, rc, rd, rx, 1'b0);
            bus.a_i = ~ra;
            bus.x_i = ~rx;
            waitDone(cycles, busyCount);
            checkOutput($sformatf("rand%0d_latency", blk), 32'(cycles), 32'd16);
            checkOutput($sformatf("rand%0d_out_a", blk), bus.out_a_o, expected[127:96]);
            checkOutput($sformatf("rand%0d_out_b", blk), bus.out_b_o, expected[95:64]);
            checkOutput($sformatf("rand%0d_out_c", blk), bus.out_c_o, expected[63:32]);
            checkOutput($sformatf("rand%0d_out_d", blk), bus.out_d_o, expected[31:0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
